// File: rtl/gate_tester_pkg.sv
// Shared definitions for the gate tester: FSM state encoding, vector index
// limits and reference truth tables for common 2-input gates.
// Truth-table bit i is the expected gate output for {x1,x2} = i.
package gate_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] LAST_IDX = 2'd3;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_tester_settle_timer.sv
// settle_timer: counts the cycles a stimulus vector has been held.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   clear_i    - force the count back to zero (has priority over en_i)
//   en_i       - advance the count by one
//   term_c_o   - combinational flag, high while the count equals SETTLE-1
module settle_timer #(
    parameter int unsigned SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic term_c_o
);

    // Wide enough to hold SETTLE itself (the count may step once past terminal).
    localparam int unsigned CW = $clog2(SETTLE + 1);

    logic [CW-1:0] cnt_q;

    // Cycle counter
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign term_c_o = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_tester.sv
// gate_tester: drives the four input vectors of a 2-input gate in order
// 00,01,10,11, holds each for SETTLE cycles, samples the gate output once
// per vector and compares it against a latched expected truth table.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start          - run request level, accepted only while idle
//   expected[3:0]  - expected truth table, latched when a run is accepted
//   x1, x2         - registered stimulus to the gate under test
//   z              - gate output, sampled in the same clock domain
//   busy           - high in every state except idle
//   done           - one-cycle pulse when a run completes
//   pass           - last completed run had no mismatch
//   fail_mask[3:0] - bit i set when vector i mismatched in the last run
module gate_tester #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       x1,
    output logic       x2,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    import gate_tester_pkg::*;

    state_e     state_q;
    logic [1:0] idx_q;
    logic [3:0] exp_q;
    logic [3:0] mask_q;
    logic [3:0] mask_d;
    logic       x1_q, x2_q, busy_q, done_q, pass_q;
    logic [3:0] fail_mask_q;
    logic       term_c;

    // Settle counter runs only while waiting; any other state holds it at zero.
    settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != ST_WAIT),
        .en_i     (state_q == ST_WAIT),
        .term_c_o (term_c)
    );

    // Working mask including the current vector's comparison; only feeds registers.
    always_comb begin
        mask_d = mask_q;
        if (z != exp_q[idx_q]) begin
            mask_d[idx_q] = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            exp_q       <= 4'd0;
            mask_q      <= 4'd0;
            x1_q        <= 1'b0;
            x2_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        exp_q       <= expected;
                        idx_q       <= 2'd0;
                        mask_q      <= 4'd0;
                        pass_q      <= 1'b0;
                        fail_mask_q <= 4'd0;
                        x1_q        <= 1'b0;
                        x2_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (term_c) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    mask_q <= mask_d;
                    if (idx_q == LAST_IDX) begin
                        // Publish results together with the done pulse.
                        fail_mask_q <= mask_d;
                        pass_q      <= (mask_d == 4'd0);
                        done_q      <= 1'b1;
                        x1_q        <= 1'b0;
                        x2_q        <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q        <= idx_q + 2'd1;
                        {x1_q, x2_q} <= idx_q + 2'd1;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x1        = x1_q;
    assign x2        = x2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench: two gate_tester instances (SETTLE=4 and SETTLE=1), each driving a
// 2-input NAND gate. Expected run results are queued at launch and checked
// when the done pulse appears.
module tb_gate_tester;

    import gate_tester_pkg::*;

    logic       clk = 1'b0;
    logic [1:0] rstv, startv, x1v, x2v, zv, busyv, donev, passv;
    logic [3:0] expv  [2];
    logic [3:0] maskv [2];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         inst;
        logic       pass;
        logic [3:0] mask;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Gates under test
    assign zv = ~(x1v & x2v);

    gate_tester #(.SETTLE(4)) dut0 (
        .clk(clk), .rst(rstv[0]), .start(startv[0]), .expected(expv[0]),
        .x1(x1v[0]), .x2(x2v[0]), .z(zv[0]), .busy(busyv[0]),
        .done(donev[0]), .pass(passv[0]), .fail_mask(maskv[0])
    );

    gate_tester #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rstv[1]), .start(startv[1]), .expected(expv[1]),
        .x1(x1v[1]), .x2(x2v[1]), .z(zv[1]), .busy(busyv[1]),
        .done(donev[1]), .pass(passv[1]), .fail_mask(maskv[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns right after the accepting edge.
    task automatic launch(input int inst, input int settle, input logic [3:0] tt,
                          input logic ep, input logic [3:0] em);
        exp_t e;
        e.inst = inst; e.pass = ep; e.mask = em; e.lat = 4 * (settle + 1);
        sb.push_back(e);
        expv[inst]   = tt;
        startv[inst] = 1'b1;
        tick();
        startv[inst] = 1'b0;
    endtask

    // Follow a run to its done pulse, checking the vector sequence on the way.
    // Optionally toggles start and changes expected mid-run (both must be ignored).
    task automatic finish(input string tag, input int inst, input int settle,
                          input bit disturb, input logic [3:0] mid_exp);
        int   lat = 0;
        int   bad = 0;
        exp_t e;
        while (donev[inst] !== 1'b1 && lat < 200) begin
            if (lat < 4 * (settle + 1) &&
                {x1v[inst], x2v[inst]} !== 2'(lat / (settle + 1))) bad++;
            if (disturb) begin
                startv[inst] = (lat < 16) ? lat[1] : 1'b0;
                if (lat == 3) expv[inst] = mid_exp;
            end
            tick();
            lat++;
        end
        startv[inst] = 1'b0;
        chk({tag, "_vec_seq"}, bad, 0);
        chk({tag, "_done"}, donev[inst], 1'b1);
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sb_inst"}, inst, e.inst);
            chk({tag, "_latency"}, lat, e.lat);
            chk({tag, "_pass"}, passv[inst], e.pass);
            chk({tag, "_mask"}, maskv[inst], e.mask);
        end
        chk({tag, "_busy_at_done"}, busyv[inst], 1'b1);
        chk({tag, "_x_at_done"}, {x1v[inst], x2v[inst]}, 2'b00);
        tick();
        chk({tag, "_done_one_cycle"}, donev[inst], 1'b0);
        chk({tag, "_idle_after"}, busyv[inst], 1'b0);
    endtask

    initial begin
        int ndone, first_at, second_at, cyc;
        logic       held_pass;
        logic [3:0] held_mask;

        rstv = 2'b11; startv = 2'b00;
        expv[0] = 4'd0; expv[1] = 4'd0;
        tick(); tick();
        chk("reset_outs0", {x1v[0], x2v[0], busyv[0], donev[0], passv[0], maskv[0]}, 9'd0);
        chk("reset_outs1", {x1v[1], x2v[1], busyv[1], donev[1], passv[1], maskv[1]}, 9'd0);
        rstv = 2'b00;
        tick();
        chk("idle_no_start", busyv[0], 1'b0);

        // Basic NAND / AND / XOR runs with SETTLE=4
        launch(0, 4, TT_NAND, 1'b1, 4'b0000);
        chk("nand_busy_after_start", busyv[0], 1'b1);
        finish("nand", 0, 4, 1'b0, 4'd0);

        launch(0, 4, TT_AND, 1'b0, 4'b1111);
        chk("and_pass_cleared", {passv[0], maskv[0]}, 5'd0);
        finish("and", 0, 4, 1'b0, 4'd0);

        // Results hold in idle while expected wanders
        held_pass = passv[0]; held_mask = maskv[0];
        for (int i = 0; i < 5; i++) begin
            expv[0] = 4'(i * 3);
            tick();
        end
        chk("and_hold_pass", passv[0], 1'b0);
        chk("and_hold_mask", maskv[0], 4'b1111);
        chk("and_hold_same", {passv[0], maskv[0]}, {held_pass, held_mask});

        launch(0, 4, TT_XOR, 1'b0, 4'b0001);
        finish("xor", 0, 4, 1'b0, 4'd0);

        // Mid-run start toggles and expected change are ignored
        launch(0, 4, TT_NAND, 1'b1, 4'b0000);
        finish("disturb", 0, 4, 1'b1, TT_AND);
        tick(); tick();
        chk("disturb_no_restart", busyv[0], 1'b0);

        // Start held high for 50 cycles: runs back-to-back via one idle cycle
        expv[0] = TT_NAND;
        startv[0] = 1'b1;
        ndone = 0; first_at = -1; second_at = -1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (donev[0] === 1'b1) begin
                ndone++;
                if (ndone == 1) first_at = c;
                if (ndone == 2) second_at = c;
                chk("held_pass", {passv[0], maskv[0]}, 5'b10000);
            end
        end
        startv[0] = 1'b0;
        chk("held_done_count", ndone, 2);
        chk("held_first_done", first_at, 20);
        chk("held_second_done", second_at, 42);
        // Third run was accepted before start dropped; let it complete.
        cyc = 0;
        while (donev[0] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        chk("held_third_done", donev[0], 1'b1);
        tick(); tick();
        chk("held_idle", busyv[0], 1'b0);

        // Reset in the middle of vector 10 aborts the run
        expv[0] = TT_NAND;
        startv[0] = 1'b1;
        tick();
        startv[0] = 1'b0;
        cyc = 0;
        while ({x1v[0], x2v[0]} !== 2'b10 && cyc < 40) begin tick(); cyc++; end
        chk("rst_reached_10", {x1v[0], x2v[0]}, 2'b10);
        rstv[0] = 1'b1;
        tick();
        rstv[0] = 1'b0;
        chk("rst_abort_outs", {x1v[0], x2v[0], busyv[0], donev[0], passv[0], maskv[0]}, 9'd0);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (donev[0] === 1'b1) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        chk("rst_still_idle", busyv[0], 1'b0);

        // Reset wins over start on the same edge
        rstv[0] = 1'b1; startv[0] = 1'b1;
        tick();
        chk("rst_priority", busyv[0], 1'b0);
        rstv[0] = 1'b0; startv[0] = 1'b0;
        tick();
        chk("rst_priority_idle", busyv[0], 1'b0);

        // SETTLE=1 instance: two cycles per vector, done 8 edges after start
        launch(1, 1, TT_NAND, 1'b1, 4'b0000);
        finish("s1_nand", 1, 1, 1'b0, 4'd0);
        launch(1, 1, TT_OR, 1'b0, 4'b1001);
        finish("s1_or", 1, 1, 1'b0, 4'd0);

        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
